// File: rtl/gpio_s2p_in.sv
// Serial-to-parallel input reader for a 74HC165-style PISO chain.
// Loads the chain, clocks out DATA_BITS bits and strobes the assembled word.
module gpio_s2p_in #(
    parameter int DATA_BITS       = 16,
    parameter int DATA_COUNT_BITS = 4,
    parameter int CLK_DIV_BITS    = 1,
    parameter bit INVERT          = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Start,
    input  logic                 sin_data,
    output logic                 sin_clk,
    output logic                 sin_ld_n,
    output logic                 busy,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid
);

    localparam int PW = CLK_DIV_BITS + 1;
    localparam logic [PW-1:0] PH_END = PW'((1 << CLK_DIV_BITS) - 1);
    localparam logic [DATA_COUNT_BITS-1:0] BIT_END =
        DATA_COUNT_BITS'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } state_t;

    state_t                     state_q, state_d;
    logic [PW-1:0]              ph_q, ph_d;
    logic [DATA_COUNT_BITS-1:0] bit_q, bit_d;
    logic [DATA_BITS-1:0]       sr_q, sr_d;
    logic [DATA_BITS-1:0]       dout_q, dout_d;
    logic                       sclk_q, sclk_d;
    logic                       ldn_q, ldn_d;
    logic                       busy_q, busy_d;
    logic                       valid_q, valid_d;
    logic                       ph_end;

    assign ph_end = (ph_q == PH_END);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ph_q    <= '0;
            bit_q   <= '0;
            sr_q    <= '0;
            dout_q  <= '0;
            sclk_q  <= 1'b0;
            ldn_q   <= 1'b1;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            dout_q  <= dout_d;
            sclk_q  <= sclk_d;
            ldn_q   <= ldn_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        dout_d  = dout_q;
        sclk_d  = sclk_q;
        ldn_d   = ldn_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                sclk_d = 1'b0;
                ldn_d  = 1'b1;
                busy_d = 1'b0;
                if (Start) begin
                    state_d = LOAD;
                    busy_d  = 1'b1;
                    ldn_d   = 1'b0;
                    ph_d    = '0;
                end
            end
            LOAD: begin
                if (ph_end) begin
                    state_d = SHIFT;
                    ldn_d   = 1'b1;
                    sclk_d  = 1'b0;
                    ph_d    = '0;
                    bit_d   = '0;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            SHIFT: begin
                if (!ph_end) begin
                    ph_d = ph_q + 1'b1;
                end else begin
                    ph_d = '0;
                    // Sample at the end of the low phase; the rise then advances the chain.
                    if (!sclk_q) begin
                        sr_d   = {sr_q[DATA_BITS-2:0], sin_data};
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == BIT_END) begin
                            dout_d  = INVERT ? ~sr_q : sr_q;
                            valid_d = 1'b1;
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sin_clk    = sclk_q;
    assign sin_ld_n   = ldn_q;
    assign busy       = busy_q;
    assign data_out   = dout_q;
    assign data_valid = valid_q;

endmodule

// File: tb/tb_gpio_s2p_in.sv
// Bench for gpio_s2p_in: two DUT configs, each fed by a 74HC165 model.
// Expected words and strobe cycles are queued at Start and popped on data_valid.
module tb_gpio_s2p_in;

    logic        clk = 1'b0;
    logic        rst;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    logic        start0, sd0, sclk0, ldn0, busy0, val0;
    logic [15:0] dout0, par0, ch0;
    logic        start1, sd1, sclk1, ldn1, busy1, val1;
    logic [15:0] dout1, par1, ch1;

    int nrise0 = 0, nrise1 = 0, ldlow0 = 0, ldlow1 = 0;

    typedef struct {
        logic [15:0] d;
        int          t;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gpio_s2p_in u_dut0 (
        .clk(clk), .rst(rst), .Start(start0), .sin_data(sd0),
        .sin_clk(sclk0), .sin_ld_n(ldn0), .busy(busy0),
        .data_out(dout0), .data_valid(val0)
    );

    gpio_s2p_in #(.INVERT(1'b1), .CLK_DIV_BITS(0)) u_dut1 (
        .clk(clk), .rst(rst), .Start(start1), .sin_data(sd1),
        .sin_clk(sclk1), .sin_ld_n(ldn1), .busy(busy1),
        .data_out(dout1), .data_valid(val1)
    );

    // 74HC165: async parallel load while low, shift on rising serial clock
    always @(posedge sclk0 or negedge ldn0)
        if (!ldn0) ch0 <= par0;
        else       ch0 <= {ch0[14:0], 1'b0};
    assign sd0 = ch0[15];

    always @(posedge sclk1 or negedge ldn1)
        if (!ldn1) ch1 <= par1;
        else       ch1 <= {ch1[14:0], 1'b0};
    assign sd1 = ch1[15];

    always @(posedge sclk0) nrise0++;
    always @(posedge sclk1) nrise1++;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        else
            n_pass++;
    endtask

    always @(negedge clk) begin
        if (!ldn0) ldlow0++;
        if (!ldn1) ldlow1++;
        if (!rst && val0) begin
            check("spur0", q0.size() != 0, 1);
            if (q0.size() != 0) begin
                exp_t e;
                e = q0.pop_front();
                check("data0", dout0, e.d);
                check("time0", cyc, e.t);
                check("busy0", busy0, 0);
                check("rise0", nrise0, 16);
                check("ld0", ldlow0, 2);
            end
            nrise0 = 0;
            ldlow0 = 0;
        end
        if (!rst && val1) begin
            check("spur1", q1.size() != 0, 1);
            if (q1.size() != 0) begin
                exp_t e;
                e = q1.pop_front();
                check("data1", dout1, e.d);
                check("time1", cyc, e.t);
                check("busy1", busy1, 0);
                check("rise1", nrise1, 16);
                check("ld1", ldlow1, 1);
            end
            nrise1 = 0;
            ldlow1 = 0;
        end
    end

    task automatic drain(input int lim);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", q0.size() + q1.size(), 0);
        q0.delete();
        q1.delete();
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_sclk"}, sclk0, 0);
        check({tag, "_ldn"}, ldn0, 1);
        check({tag, "_busy"}, busy0, 0);
        check({tag, "_dout"}, dout0, 0);
        check({tag, "_val"}, val0, 0);
    endtask

    initial begin
        rst = 1'b1;
        start0 = 1'b0; start1 = 1'b0;
        par0 = '0; par1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (5) @(negedge clk);

        @(posedge clk); #1 rst = 1'b1;
        #1 chk_reset("rst_idle");
        @(negedge clk) rst = 1'b0;
        nrise0 = 0; ldlow0 = 0;
        nrise1 = 0; ldlow1 = 0;

        repeat (100) @(negedge clk);
        check("idle_sclk", nrise0 + nrise1, 0);
        check("idle_ld", ldlow0 + ldlow1, 0);

        // single frame, with Start pulses while busy that must be ignored
        par0 = 16'hA5C3;
        start0 = 1'b1;
        q0.push_back('{16'hA5C3, cyc + 67});
        @(negedge clk) start0 = 1'b0;
        repeat (10) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        repeat (25) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        drain(200);
        repeat (80) @(negedge clk);
        check("a5c3_hold", dout0, 16'hA5C3);
        check("idle_busy", busy0, 0);

        // inverted, HALF=1
        par1 = 16'h00FF;
        start1 = 1'b1;
        q1.push_back('{16'hFF00, cyc + 34});
        @(negedge clk) start1 = 1'b0;
        drain(200);

        // Start held: back-to-back frames 67 cycles apart
        par0 = 16'h1234;
        start0 = 1'b1;
        q0.push_back('{16'h1234, cyc + 67});
        q0.push_back('{16'hFFFF, cyc + 134});
        repeat (67) @(negedge clk);
        par0 = 16'hFFFF;
        repeat (66) @(negedge clk);
        start0 = 1'b0;
        drain(200);
        repeat (80) @(negedge clk);
        check("held_dout", dout0, 16'hFFFF);

        // abort mid-frame
        par0 = 16'h5A5A;
        start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        repeat (29) @(posedge clk);
        #1 rst = 1'b1;
        #1 chk_reset("rst_mid");
        @(negedge clk) rst = 1'b0;
        nrise0 = 0; ldlow0 = 0;
        repeat (100) @(negedge clk);
        check("abort_dout", dout0, 0);

        // bit order
        par0 = 16'h8001;
        start0 = 1'b1;
        q0.push_back('{16'h8001, cyc + 67});
        @(negedge clk) start0 = 1'b0;
        drain(200);
        check("bit15", dout0[15], 1);
        check("bit0", dout0[0], 1);
        check("bits_mid", dout0[14:1], 0);

        repeat (10) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
